nr_mem_ctrl: RTL and testbench
==============================

# nr_mem_ctrl

Memory-side initiator for the nanoRisk data/instruction memory: accepts single load/store commands and block copy/fill commands from the core, then drives the memory's write port (data, write address, write enable) and read port (read address, read enable), capturing read data. It sits between the core's execute stage and the memory. It sequences multi-word operations so the core issues one command and waits for `done`.

## Interface
Parameters:
- DATA_W, 8, data word width
- ADDR_W, 4, memory address width; block length field uses the same width

Ports:
- clk  in  1  clock; all state changes on rising edge
- clr  in  1  reset, asynchronous, active-high
- req  in  1  command valid; sampled only in IDLE
- op  in  2  00 LOAD, 01 STORE, 10 COPY, 11 FILL
- addr_a  in  ADDR_W  LOAD/STORE address, COPY source, FILL start
- addr_b  in  ADDR_W  COPY destination
- len  in  ADDR_W  COPY/FILL word count; 0 means 2^ADDR_W
- wdata  in  DATA_W  STORE/FILL data
- busy  out  1  command in progress
- done  out  1  one-cycle completion pulse
- rdata  out  DATA_W  LOAD result; holds until the next LOAD completes
- mem_rdata  in  DATA_W  memory read data
- mem_wdata  out  DATA_W  memory write data
- mem_wadr  out  ADDR_W  memory write address
- mem_radr  out  ADDR_W  memory read address
- mem_wr  out  1  memory write enable
- mem_rd  out  1  memory read enable

## Operation
- All outputs are registered.
- Reset values:
  - busy, done, mem_wr, mem_rd = 0
  - rdata, mem_wdata, mem_wadr, mem_radr = 0
  - state = IDLE, word counter = 0
- States: IDLE, LD, ST, CP_RD, CP_WR, FL.
- IDLE: on an edge with req=1, latch op/addr_a/addr_b/len/wdata, set busy=1, then:
  - LOAD: mem_rd=1, mem_radr=addr_a; go to LD.
  - STORE: mem_wr=1, mem_wadr=addr_a, mem_wdata=wdata; go to ST.
  - COPY: mem_rd=1, mem_radr=src; go to CP_RD.
  - FILL: mem_wr=1, mem_wadr=addr_a, mem_wdata=wdata; go to FL.
- LD: rdata<=mem_rdata; mem_rd=0, busy=0, done=1; go to IDLE.
- ST: mem_wr=0, busy=0, done=1; go to IDLE.
- CP_RD: mem_rd=0; mem_wr=1, mem_wadr=dst, mem_wdata=mem_rdata; go to CP_WR.
- CP_WR: mem_wr=0; decrement count.
  - count remaining: src+1, dst+1, mem_rd=1, mem_radr=src; go to CP_RD.
  - last word: busy=0, done=1; go to IDLE.
- FL: decrement count.
  - words remaining: mem_wadr+1, mem_wr held at 1.
  - last word: mem_wr=0, busy=0, done=1; go to IDLE.
- Address arithmetic is modulo 2^ADDR_W; wrap from 15 to 0 is legal and silent.
- COPY is a strictly sequential forward copy: each read is issued after the previous write has committed.
  - Overlap with dst = src+1 therefore replicates mem[src] across the range. This is defined behaviour.
- req while busy=1, or during the done cycle, is ignored; there is no queue. Inputs are only latched in IDLE.
- rdata is updated only by LOAD. COPY/FILL leave it unchanged.
- mem_rd and mem_wr are never high in the same cycle.

## Timing
- Memory contract: the memory writes on the rising edge where mem_wr=1, and updates mem_rdata on the falling edge within a cycle where mem_rd=1. The controller samples mem_rdata on the next rising edge, giving a 1-cycle read latency.
- Accept edge T0:
  - LOAD/STORE: busy high T0..T1; done high for the cycle after edge T1. The next command can be accepted at edge T2.
  - COPY of n words: busy for 2n cycles; done follows the last CP_WR edge.
  - FILL of n words: busy for n cycles; mem_wr high for n consecutive cycles.
- len=0 on COPY/FILL: 16 words (ADDR_W=4); 32 and 16 busy cycles respectively.
- clr asserted at any time:
  - All outputs go to their reset values immediately (asynchronously), aborting the operation.
  - A write whose enabling edge has not yet occurred is not performed.
  - No done pulse is produced for the aborted command.
- done never coincides with busy=1.

## Test plan
- Reset/idle: assert clr mid-cycle -> all outputs 0 without a clock edge; after release with req=0 for 5 cycles -> busy=0, done=0, mem_wr=0, mem_rd=0.
- STORE then LOAD: STORE addr 4 data 0xA5, then LOAD addr 4 -> mem_wr=1 with mem_wadr=4/mem_wdata=0xA5 for exactly 1 cycle; rdata=0xA5 when done pulses; each op has 1 busy cycle.
- FILL with wrap: FILL addr_a=14, len=4, wdata=0x3C -> addresses 14,15,0,1 written on 4 consecutive cycles; done follows; busy for 4 cycles.
- COPY: mem[2..4]=0x11,0x22,0x33; COPY src=2, dst=8, len=3 -> mem[8..10]=0x11,0x22,0x33; busy for 6 cycles; rdata unchanged.
- Overlapping COPY and len=0: mem[0]=0x7E, COPY src=0, dst=1, len=3 -> mem[1..3]=0x7E. FILL len=0 -> 16 writes.
- Abort and ignore:
  - req during busy -> ignored; no extra done.
  - clr during COPY after 1 word -> outputs 0 immediately; no done; the next LOAD runs normally.

Source files
------------

// File: rtl/nr_mem_ctrl_if.sv
// Core/memory signal bundle for nr_mem_ctrl: command side from the core,
// read/write ports toward the memory. The controller uses the slave view.
interface nr_mem_ctrl_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
);
   logic              req;
   logic [1:0]        op;
   logic [ADDR_W-1:0] addr_a;
   logic [ADDR_W-1:0] addr_b;
   logic [ADDR_W-1:0] len;
   logic [DATA_W-1:0] wdata;
   logic              busy;
   logic              done;
   logic [DATA_W-1:0] rdata;
   logic [DATA_W-1:0] mem_rdata;
   logic [DATA_W-1:0] mem_wdata;
   logic [ADDR_W-1:0] mem_wadr;
   logic [ADDR_W-1:0] mem_radr;
   logic              mem_wr;
   logic              mem_rd;

   modport slave (
      input  req, op, addr_a, addr_b, len, wdata, mem_rdata,
      output busy, done, rdata, mem_wdata, mem_wadr, mem_radr, mem_wr, mem_rd
   );

   modport master (
      output req, op, addr_a, addr_b, len, wdata, mem_rdata,
      input  busy, done, rdata, mem_wdata, mem_wadr, mem_radr, mem_wr, mem_rd
   );
endinterface

// File: rtl/nr_mem_ctrl.sv
// nanoRisk memory initiator: sequences LOAD/STORE and multi-word COPY/FILL
// onto a 1-cycle-latency memory, with every output driven from a register.
module nr_mem_ctrl #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
) (
   input  logic          clk,
   input  logic          clr,
   nr_mem_ctrl_if.slave  bus
);
   localparam logic [1:0] OP_LOAD  = 2'b00;
   localparam logic [1:0] OP_STORE = 2'b01;
   localparam logic [1:0] OP_COPY  = 2'b10;
   localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {IDLE, LD, ST, CP_RD, CP_WR, FL} state_t;

   state_t            state_q;
   logic              busy_q;
   logic              done_q;
   logic [DATA_W-1:0] rdata_q;
   logic [DATA_W-1:0] mem_wdata_q;
   logic [ADDR_W-1:0] mem_wadr_q;
   logic [ADDR_W-1:0] mem_radr_q;
   logic              mem_wr_q;
   logic              mem_rd_q;
   logic [ADDR_W-1:0] src_q;
   logic [ADDR_W-1:0] dst_q;
   logic [ADDR_W-1:0] count_q;

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q     <= IDLE;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         rdata_q     <= '0;
         mem_wdata_q <= '0;
         mem_wadr_q  <= '0;
         mem_radr_q  <= '0;
         mem_wr_q    <= 1'b0;
         mem_rd_q    <= 1'b0;
         src_q       <= '0;
         dst_q       <= '0;
         count_q     <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.req) begin
                  busy_q  <= 1'b1;
                  src_q   <= bus.addr_a;
                  dst_q   <= bus.addr_b;
                  // len=0 wraps to a full 2^ADDR_W count through the decrement
                  count_q <= bus.len;
                  case (bus.op)
                     OP_LOAD: begin
                        mem_rd_q   <= 1'b1;
                        mem_radr_q <= bus.addr_a;
                        state_q    <= LD;
                     end
                     OP_STORE: begin
                        mem_wr_q    <= 1'b1;
                        mem_wadr_q  <= bus.addr_a;
                        mem_wdata_q <= bus.wdata;
                        state_q     <= ST;
                     end
                     OP_COPY: begin
                        mem_rd_q   <= 1'b1;
                        mem_radr_q <= bus.addr_a;
                        state_q    <= CP_RD;
                     end
                     default: begin
                        mem_wr_q    <= 1'b1;
                        mem_wadr_q  <= bus.addr_a;
                        mem_wdata_q <= bus.wdata;
                        state_q     <= FL;
                     end
                  endcase
               end
            end
            LD: begin
               rdata_q  <= bus.mem_rdata;
               mem_rd_q <= 1'b0;
               busy_q   <= 1'b0;
               done_q   <= 1'b1;
               state_q  <= IDLE;
            end
            ST: begin
               mem_wr_q <= 1'b0;
               busy_q   <= 1'b0;
               done_q   <= 1'b1;
               state_q  <= IDLE;
            end
            CP_RD: begin
               mem_rd_q    <= 1'b0;
               mem_wr_q    <= 1'b1;
               mem_wadr_q  <= dst_q;
               mem_wdata_q <= bus.mem_rdata;
               state_q     <= CP_WR;
            end
            CP_WR: begin
               // next read starts only after this write commits on this edge
               mem_wr_q <= 1'b0;
               count_q  <= count_q - ONE;
               if (count_q != ONE) begin
                  src_q      <= src_q + ONE;
                  dst_q      <= dst_q + ONE;
                  mem_rd_q   <= 1'b1;
                  mem_radr_q <= src_q + ONE;
                  state_q    <= CP_RD;
               end else begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= IDLE;
               end
            end
            FL: begin
               count_q <= count_q - ONE;
               if (count_q != ONE) begin
                  mem_wadr_q <= mem_wadr_q + ONE;
               end else begin
                  mem_wr_q <= 1'b0;
                  busy_q   <= 1'b0;
                  done_q   <= 1'b1;
                  state_q  <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.rdata     = rdata_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.mem_wadr  = mem_wadr_q;
   assign bus.mem_radr  = mem_radr_q;
   assign bus.mem_wr    = mem_wr_q;
   assign bus.mem_rd    = mem_rd_q;
endmodule

// File: tb/tb_nr_mem_ctrl.sv
// Bench for nr_mem_ctrl: behavioural memory plus a word-level reference
// model of memory contents, busy lengths, write addresses and rdata.
module tb_nr_mem_ctrl;
   localparam int DW = 8;
   localparam int AW = 4;
   localparam logic [1:0] OP_LD = 2'b00, OP_ST = 2'b01, OP_CP = 2'b10, OP_FL = 2'b11;

   logic clk = 1'b0;
   logic clr = 1'b1;
   always #5 clk = ~clk;

   nr_mem_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
   nr_mem_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (.clk(clk), .clr(clr), .bus(bus));

   logic [7:0] mem [16];
   logic [7:0] ref_mem [16];
   logic [7:0] last_rd;
   int errors = 0;
   int checks = 0;

   always @(posedge clk) begin
      if (clr) begin
         for (int i = 0; i < 16; i++) mem[i] <= 8'h00;
      end else if (bus.mem_wr) begin
         mem[bus.mem_wadr] <= bus.mem_wdata;
      end
   end

   always @(negedge clk) begin
      if (bus.mem_rd) bus.mem_rdata <= mem[bus.mem_radr];
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
      end
   endtask

   task automatic chk_mem(input string nm);
      int bad = 0;
      for (int i = 0; i < 16; i++) if (mem[i] !== ref_mem[i]) bad++;
      chk({nm, "_mem_mismatch_words"}, bad, 0);
   endtask

   function automatic int words(input logic [3:0] l);
      return (l == 4'd0) ? 16 : int'(l);
   endfunction

   task automatic model_apply(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                              input logic [3:0] l, input logic [7:0] w);
      logic [3:0] s, d;
      s = a;
      d = b;
      case (op)
         OP_LD: last_rd = ref_mem[a];
         OP_ST: ref_mem[a] = w;
         OP_CP: for (int i = 0; i < words(l); i++) begin
                   ref_mem[d] = ref_mem[s];
                   s++;
                   d++;
                end
         default: for (int i = 0; i < words(l); i++) begin
                     ref_mem[s] = w;
                     s++;
                  end
      endcase
   endtask

   task automatic run_cmd(input string nm, input logic [1:0] op, input logic [3:0] a,
                          input logic [3:0] b, input logic [3:0] l, input logic [7:0] w,
                          input int exp_busy, input logic [7:0] exp_rd);
      logic [3:0] exp_adr [$];
      logic [3:0] t;
      int bc = 0, wc = 0, ovl = 0, got = 0, adr_err = 0, cyc = 0;
      case (op)
         OP_ST: exp_adr.push_back(a);
         OP_CP: begin t = b; for (int i = 0; i < words(l); i++) begin exp_adr.push_back(t); t++; end end
         OP_FL: begin t = a; for (int i = 0; i < words(l); i++) begin exp_adr.push_back(t); t++; end end
         default: ;
      endcase
      @(negedge clk);
      bus.req = 1'b1; bus.op = op; bus.addr_a = a; bus.addr_b = b; bus.len = l; bus.wdata = w;
      @(negedge clk);
      bus.req = 1'b0;
      while (cyc < 100 && got == 0) begin
         if (cyc > 0) @(negedge clk);
         if (bus.busy) bc++;
         if (bus.mem_wr) begin
            if (wc >= exp_adr.size() || bus.mem_wadr != exp_adr[wc]) adr_err++;
            wc++;
         end
         if (bus.mem_rd && bus.mem_wr) ovl++;
         if (bus.done) begin
            got = 1;
            chk({nm, "_busy_at_done"}, int'(bus.busy), 0);
         end
         cyc++;
      end
      chk({nm, "_done_seen"}, got, 1);
      chk({nm, "_busy_cycles"}, bc, exp_busy);
      chk({nm, "_write_count"}, wc, exp_adr.size());
      chk({nm, "_write_addr_errs"}, adr_err, 0);
      chk({nm, "_rd_wr_overlap"}, ovl, 0);
      chk({nm, "_rdata"}, int'(bus.rdata), int'(exp_rd));
      @(negedge clk);
      chk({nm, "_done_one_cycle"}, int'(bus.done), 0);
      model_apply(op, a, b, l, w);
      chk_mem(nm);
      $display("cmd %s op=%0d a=%0d b=%0d len=%0d w=%02h busy=%0d writes=%0d rdata=%02h",
               nm, op, a, b, l, w, bc, wc, bus.rdata);
   endtask

   typedef struct {
      logic [1:0] op;
      logic [3:0] a;
      logic [3:0] b;
      logic [3:0] l;
      logic [7:0] w;
      int         busy;
      logic [7:0] rd;
   } vec_t;

   vec_t tbl [16];

   initial begin
      int dn, wc;
      logic [1:0] rop;
      logic [3:0] ra, rb, rl;
      logic [7:0] rw;

      tbl[0]  = '{OP_ST, 4'd4,  4'd0,  4'd0, 8'hA5, 1,  8'h00};
      tbl[1]  = '{OP_LD, 4'd4,  4'd0,  4'd0, 8'h00, 1,  8'hA5};
      tbl[2]  = '{OP_FL, 4'd14, 4'd0,  4'd4, 8'h3C, 4,  8'hA5};
      tbl[3]  = '{OP_ST, 4'd2,  4'd0,  4'd0, 8'h11, 1,  8'hA5};
      tbl[4]  = '{OP_ST, 4'd3,  4'd0,  4'd0, 8'h22, 1,  8'hA5};
      tbl[5]  = '{OP_ST, 4'd4,  4'd0,  4'd0, 8'h33, 1,  8'hA5};
      tbl[6]  = '{OP_CP, 4'd2,  4'd8,  4'd3, 8'h00, 6,  8'hA5};
      tbl[7]  = '{OP_LD, 4'd9,  4'd0,  4'd0, 8'h00, 1,  8'h22};
      tbl[8]  = '{OP_ST, 4'd0,  4'd0,  4'd0, 8'h7E, 1,  8'h22};
      tbl[9]  = '{OP_CP, 4'd0,  4'd1,  4'd3, 8'h00, 6,  8'h22};
      tbl[10] = '{OP_LD, 4'd3,  4'd0,  4'd0, 8'h00, 1,  8'h7E};
      tbl[11] = '{OP_FL, 4'd5,  4'd0,  4'd0, 8'h5A, 16, 8'h7E};
      tbl[12] = '{OP_LD, 4'd0,  4'd0,  4'd0, 8'h00, 1,  8'h5A};
      tbl[13] = '{OP_ST, 4'd9,  4'd0,  4'd0, 8'hC3, 1,  8'h5A};
      tbl[14] = '{OP_CP, 4'd9,  4'd12, 4'd0, 8'h00, 32, 8'h5A};
      tbl[15] = '{OP_LD, 4'd15, 4'd0,  4'd0, 8'h00, 1,  8'hC3};

      for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
      last_rd = 8'h00;
      bus.req = 1'b0; bus.op = 2'b00; bus.addr_a = '0; bus.addr_b = '0; bus.len = '0; bus.wdata = '0;

      #12 clr = 1'b0;
      repeat (5) @(negedge clk);
      chk("idle_busy", int'(bus.busy), 0);
      chk("idle_done", int'(bus.done), 0);
      chk("idle_mem_wr", int'(bus.mem_wr), 0);
      chk("idle_mem_rd", int'(bus.mem_rd), 0);
      chk("idle_rdata", int'(bus.rdata), 0);
      $display("cmd idle busy=%0d done=%0d", bus.busy, bus.done);

      for (int i = 0; i < 16; i++)
         run_cmd($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].l, tbl[i].w,
                 tbl[i].busy, tbl[i].rd);

      // req held and retargeted while busy: must not start a second command
      dn = 0; wc = 0;
      @(negedge clk);
      bus.req = 1'b1; bus.op = OP_FL; bus.addr_a = 4'd6; bus.len = 4'd5; bus.wdata = 8'h99;
      for (int k = 0; k < 24; k++) begin
         @(negedge clk);
         if (bus.done) dn++;
         if (bus.mem_wr) wc++;
         if (k == 0) begin bus.op = OP_ST; bus.addr_a = 4'd0; bus.wdata = 8'hEE; end
         if (k == 3) bus.req = 1'b0;
      end
      chk("ignore_done_count", dn, 1);
      chk("ignore_write_count", wc, 5);
      model_apply(OP_FL, 4'd6, 4'd0, 4'd5, 8'h99);
      chk_mem("ignore");
      $display("cmd ignore done=%0d writes=%0d", dn, wc);

      // abort a COPY after its first word has been written
      @(negedge clk);
      bus.req = 1'b1; bus.op = OP_CP; bus.addr_a = 4'd8; bus.addr_b = 4'd12; bus.len = 4'd4;
      @(negedge clk);
      bus.req = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2;
      chk("abort_busy_before", int'(bus.busy), 1);
      chk("abort_radr_before", int'(bus.mem_radr), 9);
      clr = 1'b1;
      #1;
      chk("abort_busy", int'(bus.busy), 0);
      chk("abort_mem_rd", int'(bus.mem_rd), 0);
      chk("abort_mem_wr", int'(bus.mem_wr), 0);
      chk("abort_mem_radr", int'(bus.mem_radr), 0);
      chk("abort_mem_wadr", int'(bus.mem_wadr), 0);
      chk("abort_mem_wdata", int'(bus.mem_wdata), 0);
      chk("abort_rdata", int'(bus.rdata), 0);
      @(negedge clk);
      clr = 1'b0;
      dn = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (bus.done) dn++;
      end
      chk("abort_no_done", dn, 0);
      ref_mem[12] = ref_mem[8];
      last_rd = 8'h00;
      chk_mem("abort");
      $display("cmd abort done=%0d", dn);
      run_cmd("after_abort_ld", OP_LD, 4'd12, 4'd0, 4'd0, 8'h00, 1, ref_mem[12]);

      for (int i = 0; i < 30; i++) begin
         rop = 2'($urandom_range(0, 3));
         ra  = 4'($urandom_range(0, 15));
         rb  = 4'($urandom_range(0, 15));
         rl  = 4'($urandom_range(0, 15));
         rw  = 8'($urandom_range(0, 255));
         run_cmd($sformatf("rnd%0d", i), rop, ra, rb, rl, rw,
                 (rop == OP_LD || rop == OP_ST) ? 1 : (rop == OP_CP) ? 2 * words(rl) : words(rl),
                 (rop == OP_LD) ? ref_mem[ra] : last_rd);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
